// File: rtl/pcs_rx_block_lock_pkg.sv
// Shared PCS definitions for the RX block-lock logic: 66b sync header
// encodings, block-lock FSM states, parameter defaults and a header
// validity helper.
package pcs_rx_block_lock_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int SH_CNT_MAX_DEF     = 64;
    localparam int SH_INVALID_MAX_DEF = 16;
    localparam int SLIP_WAIT_DEF      = 32;

    // ST_ prefix keeps the state names clear of the SLIP_WAIT parameter.
    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } lock_state_e;

    function automatic logic sh_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_block_lock_slip_timer.sv
// Post-slip settling timer. Loaded on the slip cycle; o_done rises in the
// WAIT_CYCLES-th cycle after the load so the owner spends exactly
// WAIT_CYCLES clocks waiting.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_load           : start a new wait
//   o_done           : final cycle of the wait (also high when idle)
module pcs_slip_timer #(
    parameter int WAIT_CYCLES = 32
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    output logic o_done
);

    localparam int W = $clog2(WAIT_CYCLES) + 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            cnt_q <= '0;
        else if (i_load)
            cnt_q <= W'(WAIT_CYCLES - 1);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/pcs_rx_block_lock.sv
// 10GBASE-R style block lock. Counts qualified sync headers in windows of
// SH_CNT_MAX; acquires lock after a clean window, drops it after
// SH_INVALID_MAX bad headers in one window, and requests a one-bit gearbox
// slip whenever alignment is judged wrong.
//   i_clk, i_reset_n  : clock, async active-low reset
//   i_rx_header       : 2-bit sync header from the gearbox
//   i_rx_header_valid : header qualifier
//   o_block_lock      : lock status
//   o_slip            : one-cycle slip request
//   o_header_err      : one-cycle pulse per counted invalid header
//   o_slip_count      : saturating slip count since reset
module pcs_rx_block_lock
    import pcs_rx_block_lock_pkg::*;
#(
    parameter int SH_CNT_MAX     = SH_CNT_MAX_DEF,
    parameter int SH_INVALID_MAX = SH_INVALID_MAX_DEF,
    parameter int SLIP_WAIT      = SLIP_WAIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_rx_header,
    input  logic       i_rx_header_valid,
    output logic       o_block_lock,
    output logic       o_slip,
    output logic       o_header_err,
    output logic [7:0] o_slip_count
);

    localparam int CNT_W = $clog2(SH_CNT_MAX) + 1;
    localparam int INV_W = $clog2(SH_INVALID_MAX) + 1;

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic             lock_q, lock_d;
    logic             slip_q, slip_d;
    logic             err_q, err_d;
    logic [7:0]       slip_cnt_q;
    logic             timer_load, timer_done, hdr_bad;

    assign hdr_bad = !sh_is_valid(i_rx_header);

    pcs_slip_timer #(.WAIT_CYCLES(SLIP_WAIT)) u_slip_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (timer_load),
        .o_done    (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        err_d      = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            ST_RESET_CNT: begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                state_d   = ST_TEST_SH;
            end
            ST_TEST_SH: begin
                if (i_rx_header_valid) begin
                    sh_cnt_d  = sh_cnt_q + CNT_W'(1);
                    inv_cnt_d = inv_cnt_q + INV_W'(hdr_bad);
                    err_d     = hdr_bad;
                    if (!lock_q) begin
                        // Unlocked: any bad header means wrong alignment.
                        if (hdr_bad) begin
                            slip_d     = 1'b1;
                            timer_load = 1'b1;
                            state_d    = ST_SLIP_WAIT;
                        end else if (sh_cnt_d == CNT_W'(SH_CNT_MAX)) begin
                            lock_d  = 1'b1;
                            state_d = ST_RESET_CNT;
                        end
                    end else begin
                        // Loss of lock is checked first so it wins when the
                        // last header of a window is also the fatal one.
                        if (inv_cnt_d == INV_W'(SH_INVALID_MAX)) begin
                            lock_d     = 1'b0;
                            slip_d     = 1'b1;
                            timer_load = 1'b1;
                            state_d    = ST_SLIP_WAIT;
                        end else if (sh_cnt_d == CNT_W'(SH_CNT_MAX)) begin
                            state_d = ST_RESET_CNT;
                        end
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (timer_done)
                    state_d = ST_RESET_CNT;
            end
            default: state_d = ST_RESET_CNT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_RESET_CNT;
            sh_cnt_q  <= '0;
            inv_cnt_q <= '0;
            lock_q    <= 1'b0;
            slip_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            inv_cnt_q <= inv_cnt_d;
            lock_q    <= lock_d;
            slip_q    <= slip_d;
            err_q     <= err_d;
        end
    end

    // Counts alongside the registered slip pulse so both become visible together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            slip_cnt_q <= '0;
        else if (slip_d && slip_cnt_q != 8'hFF)
            slip_cnt_q <= slip_cnt_q + 8'd1;
    end

    assign o_block_lock = lock_q;
    assign o_slip       = slip_q;
    assign o_header_err = err_q;
    assign o_slip_count = slip_cnt_q;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
module tb_pcs_rx_block_lock;

    logic       i_clk;
    logic       i_reset_n;
    logic [1:0] i_rx_header;
    logic       i_rx_header_valid;
    logic       o_block_lock;
    logic       o_slip;
    logic       o_header_err;
    logic [7:0] o_slip_count;

    typedef struct packed {
        logic       lock;
        logic       slip;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    pcs_rx_block_lock #(
        .SH_CNT_MAX     (64),
        .SH_INVALID_MAX (16),
        .SLIP_WAIT      (32)
    ) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_rx_header       (i_rx_header),
        .i_rx_header_valid (i_rx_header_valid),
        .o_block_lock      (o_block_lock),
        .o_slip            (o_slip),
        .o_header_err      (o_header_err),
        .o_slip_count      (o_slip_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Scoreboard: each entry is the output expected after the edge that
    // samples the stimulus pushed with it.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({o_block_lock, o_slip, o_header_err, o_slip_count} !== e) begin
                bad++;
                $display("FAIL sb t=%0t got lock=%b slip=%b err=%b cnt=%0d want lock=%b slip=%b err=%b cnt=%0d",
                         $time, o_block_lock, o_slip, o_header_err, o_slip_count,
                         e.lock, e.slip, e.err, e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus plus the outputs it must produce.
    task automatic cyc(input logic [1:0] h, input logic v,
                       input logic el, input logic es, input logic ee);
        exp_t e;
        i_rx_header       = h;
        i_rx_header_valid = v;
        if (es && exp_cnt < 255) exp_cnt++;
        e.lock = el;
        e.slip = es;
        e.err  = ee;
        e.cnt  = 8'(exp_cnt);
        sb.push_back(e);
        @(posedge i_clk);
        #2;
    endtask

    // Assert reset, check outputs cleared, release, then spend the one
    // cycle in which headers are not yet processed.
    task automatic do_reset(input string tag);
        i_reset_n         = 1'b0;
        i_rx_header_valid = 1'b0;
        i_rx_header       = 2'b00;
        exp_cnt           = 0;
        #1;
        total++;
        if ({o_block_lock, o_slip, o_header_err, o_slip_count} !== 11'd0) begin
            bad++;
            $display("FAIL %s reset outputs got lock=%b slip=%b err=%b cnt=%0d want all 0",
                     tag, o_block_lock, o_slip, o_header_err, o_slip_count);
        end
        repeat (2) @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_after_slip(input logic [1:0] h);
        repeat (32) cyc(h, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset("test_reset");
        repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lock();
        do_reset("test_lock");
        for (int i = 1; i <= 64; i++)
            cyc((i % 2) ? 2'b01 : 2'b10, 1'b1, i == 64, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_slip();
        do_reset("test_slip");
        for (int i = 1; i <= 9; i++) cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_after_slip(2'b11);
        for (int i = 1; i <= 64; i++) cyc(2'b10, 1'b1, i == 64, 1'b0, 1'b0);
        total++;
        if (o_slip_count !== 8'd1) begin
            bad++;
            $display("FAIL test_slip count got %0d want 1", o_slip_count);
        end
    endtask

    // Continues from the locked state left by test_slip.
    task automatic test_locked_window();
        logic b;
        cyc(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            b = (i % 4 == 0) && (i < 64);
            cyc(b ? ((i % 8 == 0) ? 2'b00 : 2'b11) : 2'b01, 1'b1, 1'b1, 1'b0, b);
        end
        cyc(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++)
            cyc(2'b00, 1'b1, i < 16, i == 16, 1'b1);
        wait_after_slip(2'b00);
    endtask

    task automatic test_edge_priority();
        logic b;
        for (int i = 1; i <= 64; i++) cyc(2'b01, 1'b1, i == 64, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            b = (i % 4 == 0);
            cyc(b ? 2'b11 : 2'b10, 1'b1, i < 64, i == 64, b);
        end
        wait_after_slip(2'b01);
    endtask

    task automatic test_toggle_valid();
        do_reset("test_toggle_valid");
        for (int i = 0; i < 130; i++)
            cyc(2'b01, (i % 2) == 0, i >= 126, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back_slips();
        do_reset("test_back_to_back_slips");
        for (int s = 0; s < 301; s++) begin
            cyc(2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
            if (s < 300) repeat (33) cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        repeat (5) cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (o_slip_count !== 8'd255) begin
            bad++;
            $display("FAIL sat count got %0d want 255", o_slip_count);
        end
        do_reset("midwait");
        for (int i = 1; i <= 64; i++) cyc(2'b01, 1'b1, i == 64, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midwindow();
        do_reset("test_reset_midwindow");
        for (int i = 1; i <= 64; i++) cyc(2'b10, 1'b1, i == 64, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (o_block_lock !== 1'b1) begin
            bad++;
            $display("FAIL midwindow pre-reset lock got %b want 1", o_block_lock);
        end
        do_reset("midwindow");
        for (int i = 1; i <= 64; i++) cyc(2'b01, 1'b1, i == 64, 1'b0, 1'b0);
    endtask

    initial begin
        i_reset_n         = 1'b0;
        i_rx_header       = 2'b00;
        i_rx_header_valid = 1'b0;
        test_reset();
        test_lock();
        test_slip();
        test_locked_window();
        test_edge_priority();
        test_toggle_valid();
        test_back_to_back_slips();
        test_reset_midwindow();
        repeat (2) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcs_rx_block_lock.md
PCS_RX_BLOCK_LOCK -- requirements
Module: pcs_rx_block_lock

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64, meaning headers per test window.
REQ-002 SHALL have parameter SH_INVALID_MAX, default 16, meaning invalid headers per window that drop lock.
REQ-003 SHALL have parameter SLIP_WAIT, default 32, meaning clocks to ignore headers after a slip, for gearbox settling.
REQ-004 SHALL have port i_clk, input, 1, the single clock for the block.
REQ-005 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_rx_header, input, 2, 66b sync header from the RX gearbox.
REQ-007 SHALL have port i_rx_header_valid, input, 1, header qualifier that is not asserted every cycle.
REQ-008 SHALL have port o_block_lock, output, 1, Clause-49 block lock status.
REQ-009 SHALL have port o_slip, output, 1, one-cycle request to the gearbox to shift one bit.
REQ-010 SHALL have port o_header_err, output, 1, one-cycle pulse per qualified invalid header.
REQ-011 SHALL have port o_slip_count, output, 8, saturating count of slips since reset.

Function
REQ-012 SHALL treat a header as valid iff it is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-013 SHALL sample i_rx_header only in cycles where i_rx_header_valid=1; all counters SHALL hold otherwise.
REQ-014 SHALL implement an FSM with states RESET_CNT, TEST_SH and SLIP_WAIT.
REQ-015 RESET_CNT SHALL clear sh_cnt and sh_invalid_cnt, then enter TEST_SH on the next cycle.
REQ-016 TEST_SH with a qualified header SHALL increment sh_cnt, and SHALL increment sh_invalid_cnt when the header is invalid.
REQ-017 When unlocked, the first invalid header SHALL assert o_slip and o_header_err in the following cycle and enter SLIP_WAIT; o_block_lock stays 0.
REQ-018 When unlocked and sh_cnt reaches SH_CNT_MAX with zero invalid headers, o_block_lock SHALL assert in the following cycle and the FSM SHALL enter RESET_CNT.
REQ-019 When locked and sh_invalid_cnt reaches SH_INVALID_MAX within a window, o_block_lock SHALL deassert, o_slip SHALL pulse and the FSM SHALL enter SLIP_WAIT.
REQ-020 When locked and sh_cnt reaches SH_CNT_MAX with fewer than SH_INVALID_MAX invalids, the FSM SHALL enter RESET_CNT and lock SHALL be retained.
REQ-021 If the last header of a window is also the SH_INVALID_MAX-th invalid header, loss of lock SHALL take priority over window completion.
REQ-022 SLIP_WAIT SHALL count SLIP_WAIT clocks regardless of i_rx_header_valid, then enter RESET_CNT; qualified headers during the wait SHALL be ignored and SHALL raise no o_header_err.
REQ-023 o_slip SHALL be exactly one cycle wide and SHALL NOT be reasserted before SLIP_WAIT expires.
REQ-024 o_slip_count SHALL increment on each o_slip pulse and SHALL saturate at 255.
REQ-025 sh_cnt SHALL be clog2(SH_CNT_MAX)+1 bits wide; sh_invalid_cnt SHALL be clog2(SH_INVALID_MAX)+1 bits wide; neither counter SHALL wrap.

Reset
REQ-026 While i_reset_n=0: FSM=RESET_CNT; o_block_lock, o_slip, o_header_err = 0; o_slip_count=0; all counters = 0.
REQ-027 Reset asserted mid-window or mid-SLIP_WAIT SHALL immediately drop o_block_lock and abort the wait.
REQ-028 After i_reset_n deassertion, header processing SHALL begin on the second rising edge of i_clk.

Structure
REQ-029 Header encodings (SYNC_DATA=2'b01, SYNC_CTRL=2'b10), the FSM state enum and the parameter defaults SHALL live in the shared PCS package.
REQ-030 The SLIP_WAIT down-counter MAY be a sub-module named pcs_slip_timer; all other logic SHALL be flat.

Verification
REQ-031 Stimulus: 64 valid headers, valid every cycle -> o_block_lock=1 one cycle after the 64th header; o_slip never asserted.
REQ-032 Stimulus: 2'b11 as the 10th header while unlocked -> o_slip and o_header_err pulse once; o_slip_count=1; the 32 headers that follow are ignored; the next 64 valid headers -> lock.
REQ-033 Stimulus: while locked, 15 invalid headers in a 64-header window -> lock retained; 16 invalid headers -> lock drops and o_slip pulses.
REQ-034 Stimulus: while locked, the 16th invalid header arrives as the 64th header of the window -> lock drops (REQ-021).
REQ-035 Stimulus: i_rx_header_valid toggling 1/0 every cycle -> lock after exactly 128 clocks of valid headers.
REQ-036 Stimulus: 300 forced slips -> o_slip_count=255; then i_reset_n pulsed low mid-wait -> all outputs 0.
